uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the write port of the UART TX FIFO between N_REQ byte-stream requesters.
//  Grants whole packets (terminated by req_last) round-robin, so bytes from different
//  sources never interleave on the serial line. Sits in the fifo_tx_clk domain and
//  drives fifo_tx_req/fifo_tx_data/fifo_full of the UART TX FIFO controller.
//  Forces release on over-length packets and on stalled grantees.
// PARAMETERS
//  N_REQ        4    number of requesters, 2..8; ID_W = $clog2(N_REQ)
//  MAX_PKT_LEN  64   max bytes per grant; forced release after this many, 1..255
//  IDLE_TIMEOUT 256  cycles the grantee may hold req_valid low mid-packet before abort, 2..65535
// PORTS
//  fifo_tx_clk  in   1          single clock, all logic on rising edge
//  reset_n      in   1          asynchronous, active-low reset
//  req_valid    in   N_REQ      per-requester byte valid
//  req_data     in   8*N_REQ    per-requester byte, requester i at [8*i+7:8*i]
//  req_last     in   N_REQ      byte is last of packet (qualified by valid&ready)
//  req_ready    out  N_REQ      byte accepted this cycle when valid&ready
//  fifo_tx_req  out  1          FIFO write strobe
//  fifo_tx_data out  8          FIFO write data
//  fifo_full    in   1          FIFO full; no write while high
//  grant_valid  out  1          a requester currently owns the FIFO
//  grant_id     out  ID_W       index of owner (valid when grant_valid)
//  pkt_done     out  1          1-cycle pulse: grant ended normally (last or length limit)
//  pkt_abort    out  1          1-cycle pulse: grant ended by IDLE_TIMEOUT
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=N_REQ-1, byte_cnt=0, idle_cnt=0; all outputs 0.
//  Reset mid-packet drops grant immediately; no partial-packet recovery.
//  States: IDLE, XFER.
//  IDLE: if any req_valid, choose first set bit scanning from rr_ptr+1 (mod N_REQ)
//   upward; register grant_id, grant_valid=1, go XFER. One cycle arbitration
//   latency; no byte moves in the IDLE cycle. No request -> stay IDLE.
//  XFER (owner g): combinational
//   req_ready[g] = ~fifo_full; req_ready[others] = 0
//   fifo_tx_req  = req_valid[g] & ~fifo_full; fifo_tx_data = req_data[g]
//   (fifo_tx_data = 0 outside XFER). Write = fifo_tx_req.
//  On write: byte_cnt++, idle_cnt=0. If req_last[g] or byte_cnt==MAX_PKT_LEN-1:
//   next state IDLE, rr_ptr=g, byte_cnt=0, pkt_done=1 next cycle, grant_valid=0.
//  req_valid[g]=0 in XFER: idle_cnt++; when idle_cnt==IDLE_TIMEOUT-1 -> IDLE,
//   rr_ptr=g, pkt_abort=1 next cycle, counters cleared.
//  fifo_full high with req_valid[g] high: stall, idle_cnt held (not a timeout).
//  Requester changes valid in other lanes during XFER: ignored until next IDLE.
//  Simultaneous last and length limit: single pkt_done.
//  Minimum spacing between grants: 1 IDLE cycle; back-to-back packets from one
//   requester are allowed only when no other requester is valid (fairness).
//  byte_cnt 8 bit, idle_cnt 16 bit; neither wraps (both cleared on release).
// TESTING
//  Single req0, 3 bytes 0x41,0x42,0x43 last on 3rd -> FIFO gets 41,42,43; grant 1 cycle after valid; pkt_done pulses once.
//  req0..req3 all valid, 2-byte packets each -> grant order 0,1,2,3,0; no interleave; rr_ptr updates.
//  fifo_full held 10 cycles mid-packet -> fifo_tx_req=0, req_ready=0, no abort; resumes with next byte intact.
//  MAX_PKT_LEN=4, req1 sends 6 bytes no last -> 4 bytes written, pkt_done, req2 (pending) granted next.
//  IDLE_TIMEOUT=8, req2 drops valid after 1 byte -> pkt_abort 8 cycles later, grant moves on.
//  reset_n low during XFER -> all outputs 0 asynchronously; after release, fresh arbitration from index 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter on the UART TX FIFO write port: one requester owns the FIFO per whole packet.
// Latency: 1 cycle to arbitrate, then up to 1 byte/cycle; backpressure: fifo_full drops req_ready and stalls the owner without aging its timeout.
module uart_tx_arbiter #(
    parameter  int N_REQ        = 4,
    parameter  int MAX_PKT_LEN  = 64,
    parameter  int IDLE_TIMEOUT = 256,
    localparam int ID_W         = $clog2(N_REQ)
) (
    input  logic                 fifo_tx_clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 fifo_tx_req,
    output logic [7:0]           fifo_tx_data,
    input  logic                 fifo_full,
    output logic                 grant_valid,
    output logic [ID_W-1:0]      grant_id,
    output logic                 pkt_done,
    output logic                 pkt_abort
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam logic [7:0]  LEN_LAST = 8'(MAX_PKT_LEN - 1);
    localparam logic [15:0] TO_LAST  = 16'(IDLE_TIMEOUT - 1);

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [7:0]      byte_cnt;
    logic [15:0]     idle_cnt;

    logic            pick_vld;
    logic [ID_W-1:0] pick_id;
    logic [ID_W-1:0] cand;
    logic            own_valid;
    logic            own_last;
    logic [7:0]      own_data;

    // Scan downward so the candidate closest to rr_ptr+1 is the last one to win.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (req_valid[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    always_comb begin
        req_ready    = '0;
        fifo_tx_req  = 1'b0;
        fifo_tx_data = 8'h00;
        own_valid    = req_valid[grant_id];
        own_last     = req_last[grant_id];
        own_data     = req_data[{grant_id, 3'b000} +: 8];
        if (state == XFER) begin
            req_ready[grant_id] = ~fifo_full;
            fifo_tx_req         = own_valid & ~fifo_full;
            fifo_tx_data        = own_data;
        end
    end

    always_ff @(posedge fifo_tx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rr_ptr      <= ID_W'(N_REQ - 1);
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            pkt_done    <= 1'b0;
            pkt_abort   <= 1'b0;
        end else begin
            pkt_done  <= 1'b0;
            pkt_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state       <= XFER;
                        grant_valid <= 1'b1;
                        grant_id    <= pick_id;
                        byte_cnt    <= '0;
                        idle_cnt    <= '0;
                    end
                end
                XFER: begin
                    if (fifo_tx_req) begin
                        if (own_last || byte_cnt == LEN_LAST) begin
                            state       <= IDLE;
                            grant_valid <= 1'b0;
                            grant_id    <= '0;
                            rr_ptr      <= grant_id;
                            byte_cnt    <= '0;
                            idle_cnt    <= '0;
                            pkt_done    <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                            idle_cnt <= '0;
                        end
                    end else if (!own_valid) begin
                        // A full FIFO with data waiting is a stall, so only an absent owner ages.
                        if (idle_cnt == TO_LAST) begin
                            state       <= IDLE;
                            grant_valid <= 1'b0;
                            grant_id    <= '0;
                            rr_ptr      <= grant_id;
                            byte_cnt    <= '0;
                            idle_cnt    <= '0;
                            pkt_abort   <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a per-cycle packet-level reference model.
module tb_uart_tx_arbiter;
    localparam int N_REQ        = 4;
    localparam int MAX_PKT_LEN  = 4;
    localparam int IDLE_TIMEOUT = 8;
    localparam int ID_W         = 2;

    logic               fifo_tx_clk = 1'b0;
    logic               reset_n     = 1'b1;
    logic [N_REQ-1:0]   req_valid   = '0;
    logic [8*N_REQ-1:0] req_data    = '0;
    logic [N_REQ-1:0]   req_last    = '0;
    logic [N_REQ-1:0]   req_ready;
    logic               fifo_tx_req;
    logic [7:0]         fifo_tx_data;
    logic               fifo_full   = 1'b0;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic               pkt_done;
    logic               pkt_abort;

    uart_tx_arbiter #(
        .N_REQ(N_REQ), .MAX_PKT_LEN(MAX_PKT_LEN), .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .fifo_tx_clk (fifo_tx_clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .fifo_tx_req (fifo_tx_req),
        .fifo_tx_data(fifo_tx_data),
        .fifo_full   (fifo_full),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .pkt_done    (pkt_done),
        .pkt_abort   (pkt_abort)
    );

    initial forever #5 fifo_tx_clk = ~fifo_tx_clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0]       src_q [N_REQ][$];
    logic [N_REQ-1:0] acc = '0;
    logic [7:0]       wr_log[$];
    int               gnt_log[$];
    logic [7:0]       exp_b[$];
    int               exp_g[$];
    int cyc = 0, valid_rise_cyc = 0, gnt_rise_cyc = 0, first_wr_cyc = 0, abort_cyc = 0;
    int n_done = 0, n_abort = 0;
    logic prev_gv = 1'b0, prev_any_v = 1'b0;

    // Reference model: owner (-1 = none), bytes sent, consecutive absent cycles.
    int m_owner = -1, m_rr = N_REQ - 1, m_cnt = 0, m_idle = 0;
    bit m_done = 0, m_abort = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge fifo_tx_clk) begin
        logic [17:0] exp_v, act_v;
        logic [N_REQ-1:0] e_rdy;
        logic [7:0] e_dat;
        logic e_req;
        int g, c;
        cyc++;
        if (!reset_n) begin
            m_owner = -1; m_rr = N_REQ - 1; m_cnt = 0; m_idle = 0; m_done = 0; m_abort = 0;
        end
        g     = m_owner;
        e_rdy = (g >= 0 && !fifo_full) ? (4'b0001 << g) : 4'b0000;
        e_req = (g >= 0) ? (req_valid[g] & ~fifo_full) : 1'b0;
        e_dat = (g >= 0) ? req_data[8*g +: 8] : 8'h00;
        exp_v = {(g >= 0), (g >= 0) ? 2'(g) : 2'd0, m_done, m_abort, e_rdy, e_req, e_dat};
        act_v = {grant_valid, grant_id, pkt_done, pkt_abort, req_ready, fifo_tx_req, fifo_tx_data};
        chk("cycle_outputs", 32'(act_v), 32'(exp_v));

        acc = req_valid & req_ready;
        if (fifo_tx_req) begin
            if (wr_log.size() == 0) first_wr_cyc = cyc;
            wr_log.push_back(fifo_tx_data);
        end
        if (grant_valid && !prev_gv) begin
            gnt_log.push_back(int'(grant_id));
            gnt_rise_cyc = cyc;
        end
        if ((|req_valid) && !prev_any_v) valid_rise_cyc = cyc;
        if (pkt_done) n_done++;
        if (pkt_abort) begin
            n_abort++;
            abort_cyc = cyc;
        end
        prev_gv    = grant_valid;
        prev_any_v = |req_valid;

        if (reset_n) begin
            m_done = 0; m_abort = 0;
            if (g < 0) begin
                for (int k = 1; k <= N_REQ; k++) begin
                    c = (m_rr + k) % N_REQ;
                    if (req_valid[c]) begin
                        m_owner = c; m_cnt = 0; m_idle = 0;
                        break;
                    end
                end
            end else if (req_valid[g] && !fifo_full) begin
                m_cnt++; m_idle = 0;
                if (req_last[g] || m_cnt == MAX_PKT_LEN) begin
                    m_done = 1; m_rr = g; m_owner = -1; m_cnt = 0;
                end
            end else if (!req_valid[g]) begin
                m_idle++;
                if (m_idle == IDLE_TIMEOUT) begin
                    m_abort = 1; m_rr = g; m_owner = -1; m_cnt = 0; m_idle = 0;
                end
            end
        end
    end

    task automatic drive();
        logic [8:0] h;
        for (int i = 0; i < N_REQ; i++) begin
            h = (src_q[i].size() > 0) ? src_q[i][0] : 9'h000;
            req_valid[i]       = (src_q[i].size() > 0);
            req_last[i]        = h[8];
            req_data[8*i +: 8] = h[7:0];
        end
    endtask

    task automatic step();
        @(posedge fifo_tx_clk);
        #1;
        for (int i = 0; i < N_REQ; i++)
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drive();
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N_REQ; i++)
            if (src_q[i].size() != 0) return 0;
        return 1;
    endfunction

    task automatic wait_idle(input string name, input int max_cyc);
        int n = 0;
        while (!(queues_empty() && !grant_valid && !pkt_done && !pkt_abort && req_valid == '0)) begin
            if (n >= max_cyc) begin
                n_checks++;
                $display("FAIL %s_wait: still busy after %0d cycles, expected idle", name, n);
                return;
            end
            step();
            n++;
        end
    endtask

    task automatic wait_bytes(input string name, input int nb, input int max_cyc);
        int n = 0;
        while (wr_log.size() < nb) begin
            if (n >= max_cyc) begin
                n_checks++;
                $display("FAIL %s_wait: %0d bytes after %0d cycles, expected %0d", name, wr_log.size(), n, nb);
                return;
            end
            step();
            n++;
        end
    endtask

    task automatic clear_obs();
        wr_log.delete();
        gnt_log.delete();
        n_done  = 0;
        n_abort = 0;
    endtask

    task automatic cmp_logs(input string name);
        chk({name, "_nbytes"}, wr_log.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < wr_log.size(); i++)
            chk({name, "_byte"}, 32'(wr_log[i]), 32'(exp_b[i]));
        chk({name, "_ngrants"}, gnt_log.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < gnt_log.size(); i++)
            chk({name, "_grant"}, gnt_log[i], exp_g[i]);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < N_REQ; i++) src_q[i].delete();
        drive();
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(posedge fifo_tx_clk);
        #1;
        chk("reset_outputs",
            32'({grant_valid, grant_id, pkt_done, pkt_abort, req_ready, fifo_tx_req, fifo_tx_data}), 32'h0);
        reset_n = 1'b1;

        // Single 3-byte packet from lane 0.
        clear_obs();
        src_q[0] = '{9'h041, 9'h042, 9'h143};
        drive();
        wait_idle("t1", 40);
        exp_b = '{8'h41, 8'h42, 8'h43};
        exp_g = '{0};
        cmp_logs("t1");
        chk("t1_grant_latency", gnt_rise_cyc - valid_rise_cyc, 1);
        chk("t1_done_pulses", n_done, 1);

        // All lanes busy: round-robin from lane 0, lane 0 comes back last.
        step();
        do_reset();
        clear_obs();
        src_q[0] = '{9'h0A0, 9'h1A1, 9'h0A2, 9'h1A3};
        src_q[1] = '{9'h0B0, 9'h1B1};
        src_q[2] = '{9'h0C0, 9'h1C1};
        src_q[3] = '{9'h0D0, 9'h1D1};
        drive();
        wait_idle("t2", 100);
        exp_b = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hD0, 8'hD1, 8'hA2, 8'hA3};
        exp_g = '{0, 1, 2, 3, 0};
        cmp_logs("t2");
        chk("t2_done_pulses", n_done, 5);

        // FIFO full for 10 cycles mid-packet: stall, no timeout.
        clear_obs();
        src_q[0] = '{9'h061, 9'h062, 9'h163};
        drive();
        wait_bytes("t3", 1, 20);
        fifo_full = 1'b1;
        step();
        chk("t3_stall", 32'({req_ready, fifo_tx_req}), 32'h0);
        repeat (9) step();
        chk("t3_grant_held", 32'(grant_valid), 32'h1);
        fifo_full = 1'b0;
        wait_idle("t3", 40);
        exp_b = '{8'h61, 8'h62, 8'h63};
        exp_g = '{0};
        cmp_logs("t3");
        chk("t3_abort_pulses", n_abort, 0);
        chk("t3_done_pulses", n_done, 1);

        // Length limit 4: lane 1 cut after 4 bytes, pending lane 2 goes next.
        clear_obs();
        src_q[1] = '{9'h071, 9'h072, 9'h073, 9'h074, 9'h075, 9'h076};
        src_q[2] = '{9'h181};
        drive();
        wait_idle("t4", 100);
        exp_b = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h81, 8'h75, 8'h76};
        exp_g = '{1, 2, 1};
        cmp_logs("t4");
        chk("t4_done_pulses", n_done, 2);
        chk("t4_abort_pulses", n_abort, 1);

        // Idle timeout 8: lane 2 sends one byte and goes silent, lane 3 waits.
        clear_obs();
        src_q[2] = '{9'h0A5};
        src_q[3] = '{9'h191};
        drive();
        wait_idle("t5", 60);
        exp_b = '{8'hA5, 8'h91};
        exp_g = '{2, 3};
        cmp_logs("t5");
        chk("t5_abort_delay", abort_cyc - first_wr_cyc, 9);
        chk("t5_abort_pulses", n_abort, 1);
        chk("t5_done_pulses", n_done, 1);

        // Reset mid-packet, then arbitration restarts from lane 0.
        clear_obs();
        src_q[2] = '{9'h1C2};
        drive();
        wait_idle("t6a", 30);
        src_q[1] = '{9'h0D1, 9'h0D2, 9'h1D3};
        drive();
        wait_bytes("t6", 2, 20);
        reset_n = 1'b0;
        #1;
        chk("t6_async_reset",
            32'({grant_valid, grant_id, pkt_done, pkt_abort, req_ready, fifo_tx_req, fifo_tx_data}), 32'h0);
        for (int i = 0; i < N_REQ; i++) src_q[i].delete();
        drive();
        step();
        step();
        reset_n = 1'b1;
        src_q[1] = '{9'h1B1};
        src_q[3] = '{9'h1B3};
        drive();
        wait_idle("t6b", 40);
        exp_b = '{8'hC2, 8'hD1, 8'hB1, 8'hB3};
        exp_g = '{2, 1, 1, 3};
        cmp_logs("t6");

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
